pc_redirect_ctrl: RTL and testbench
===================================

Name: pc_redirect_ctrl

Overview:
- Fetch-side consumer of the EX-stage branch/jump resolution (`pcsrc`, target) produced by the registered ALU.
- Owns the architectural PC register and the sequential wrong-path flush window.
- Emits flush strobes to the IF/ID and ID/EX pipeline registers, honours load-use stalls, and keeps a redirect performance counter plus a sticky misalignment flag.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- FLUSH_CYCLES, 2, number of consecutive cycles the flush strobes are asserted per redirect (range 1..7).
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  synchronous reset, active-low.
- stall  in  1  hazard-unit stall request; hold PC.
- pcsrc  in  1  redirect request from EX (registered ALU output).
- target  in  32  redirect destination from EX.
- pc  out  32  current fetch address (registered).
- pc_plus4  out  32  pc + 4, combinational, modulo 2^32.
- if_valid  out  1  fetched instruction is on the correct path.
- flush_ifid  out  1  clear IF/ID register.
- flush_idex  out  1  clear ID/EX register.
- busy  out  1  high while state is FLUSH.
- redirect_cnt  out  CNT_W  number of accepted redirects, saturating.
- misalign  out  1  sticky: an accepted target had target[1:0] != 0.

Behaviour:
- Reset: synchronous. When rst_n is sampled low, the block enters the following state:
  - pc = RESET_PC; state = RUN; flush counter = 0.
  - redirect_cnt = 0; misalign = 0.
  - flush_ifid = flush_idex = busy = 0; if_valid = 0 for the reset cycle.
- Reset has priority over every other input. Reset asserted mid-FLUSH aborts the window immediately; no flush strobe appears in the cycle after reset.
- Two states: RUN and FLUSH.
- RUN, pcsrc = 1 (accepted redirect; pcsrc wins over stall):
  - next pc = {target[31:2], 2'b00}.
  - flush_ifid = flush_idex = 1 combinationally in the same cycle.
  - flush counter loads FLUSH_CYCLES-1. Go to FLUSH, or stay in RUN if FLUSH_CYCLES = 1.
  - redirect_cnt increments, saturating at all-ones.
  - misalign is set if target[1:0] != 0.
- RUN, pcsrc = 0, stall = 1: pc holds. No flush. if_valid = 1.
- RUN, pcsrc = 0, stall = 0: pc <= pc_plus4. if_valid = 1.
- FLUSH:
  - flush_ifid = flush_idex = 1; busy = 1; if_valid = 0.
  - pcsrc is ignored: it comes from a killed instruction. No counter change, no misalign update.
  - pc advances by 4 from the target unless stall = 1. Stall freezes pc but does not freeze the flush counter.
  - Counter decrements each cycle. When the counter is 0, return to RUN next cycle.
- Flush window length: exactly FLUSH_CYCLES cycles of asserted strobes per accepted redirect, counting the cycle where pcsrc was sampled.
- Back-to-back: pcsrc high in the first RUN cycle after FLUSH is a new accepted redirect.
- Wrap: pc 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- pcsrc = 1 with stall = 1: redirect is taken and stall is overridden for the PC. Stall remains the hazard unit's concern for downstream registers.
- No X propagation: target is only sampled when pcsrc is accepted.

Test Plan:
- Reset then 3 free-run cycles, stall=0 -> pc sequence 0x3000, 0x3004, 0x3008, 0x300C; flush strobes low; redirect_cnt=0.
- At pc=0x3008, drive pcsrc=1 with target=0x3040 for one cycle -> flush strobes high that cycle and the next (2 cycles total), busy high for 1 cycle, pc=0x3040 then 0x3044; redirect_cnt=1.
- pcsrc=1 again during FLUSH with target=0x5000 -> ignored: pc continues 0x3044, redirect_cnt stays 1. Then pcsrc=1 in the first RUN cycle -> accepted, pc=0x5000, redirect_cnt=2.
- stall=1 for 3 cycles at pc=0x3010, then pcsrc+stall together with target=0x3102 -> pc holds 0x3010 for 3 cycles, then pc=0x3100, misalign=1 sticky until reset.
- Force pc to 0xFFFFFFF8 via redirect, run 3 cycles -> 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Drive rst_n low during the second FLUSH cycle -> next cycle pc=0x3000, busy=0, flush strobes=0, redirect_cnt=0, misalign=0. Separately, CNT_W=4 with 17 redirects -> redirect_cnt saturates at 15.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// Fetch-side PC owner: applies EX-stage redirects, drives the wrong-path flush
// window into IF/ID and ID/EX, and tracks redirect count and target misalignment.
module pc_redirect_ctrl #(
   parameter logic [31:0] RESET_PC     = 32'h0000_3000,
   parameter int          FLUSH_CYCLES = 2,
   parameter int          CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             pcsrc,
   input  logic [31:0]      target,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   output logic             if_valid,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             busy,
   output logic [CNT_W-1:0] redirect_cnt,
   output logic             misalign
);

   typedef enum logic {RUN, FLUSH} state_t;

   // Remaining FLUSH-state cycles after the redirect cycle itself.
   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   state_t      state, state_next;
   logic [2:0]  fcnt, fcnt_next;
   logic [31:0] pc_next;
   logic        accept;
   logic        strobe;

   assign pc_plus4 = pc + 32'd4;

   always_comb begin
      state_next = state;
      fcnt_next  = fcnt;
      pc_next    = pc;
      accept     = 1'b0;
      case (state)
         RUN: begin
            if (pcsrc) begin
               // Redirect wins over stall; the target is only looked at here.
               accept     = 1'b1;
               pc_next    = {target[31:2], 2'b00};
               fcnt_next  = FLUSH_LOAD;
               state_next = (FLUSH_LOAD == 3'd0) ? RUN : FLUSH;
            end else if (!stall) begin
               pc_next = pc_plus4;
            end
         end
         FLUSH: begin
            // pcsrc here belongs to a killed instruction and is ignored.
            fcnt_next  = (fcnt == 3'd0) ? 3'd0 : fcnt - 3'd1;
            state_next = (fcnt <= 3'd1) ? RUN : FLUSH;
            if (!stall) pc_next = pc_plus4;
         end
         default: state_next = RUN;
      endcase
   end

   // Reset dominates the outputs combinationally so a window aborted by reset
   // shows no strobe even in the reset cycle.
   assign strobe     = rst_n && ((state == FLUSH) || pcsrc);
   assign flush_ifid = strobe;
   assign flush_idex = strobe;
   assign busy       = rst_n && (state == FLUSH);
   assign if_valid   = rst_n && !strobe;

   // NOTE: all state below uses non-blocking assignments with the synchronous
   // reset as the first branch, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= RUN;
         fcnt         <= 3'd0;
         pc           <= RESET_PC;
         redirect_cnt <= '0;
         misalign     <= 1'b0;
      end else begin
         state <= state_next;
         fcnt  <= fcnt_next;
         pc    <= pc_next;
         if (accept) begin
            if (redirect_cnt != '1) redirect_cnt <= redirect_cnt + 1'b1;
            if (target[1:0] != 2'b00) misalign <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios plus random
// traffic against a window-counting reference model, and a saturation check.
module tb_pc_redirect_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance, default parameters.
   logic        rst_n, stall, pcsrc;
   logic [31:0] target;
   logic [31:0] pc, pc_plus4;
   logic        if_valid, flush_ifid, flush_idex, busy, misalign;
   logic [15:0] redirect_cnt;

   pc_redirect_ctrl dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .pcsrc(pcsrc), .target(target),
      .pc(pc), .pc_plus4(pc_plus4), .if_valid(if_valid), .flush_ifid(flush_ifid),
      .flush_idex(flush_idex), .busy(busy), .redirect_cnt(redirect_cnt),
      .misalign(misalign)
   );

   // Narrow-counter, single-cycle-window instance.
   logic        b_rst_n, b_stall, b_pcsrc;
   logic [31:0] b_target;
   logic [31:0] b_pc, b_pc_plus4;
   logic        b_if_valid, b_flush_ifid, b_flush_idex, b_busy, b_misalign;
   logic [3:0]  b_redirect_cnt;

   pc_redirect_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(b_rst_n), .stall(b_stall), .pcsrc(b_pcsrc), .target(b_target),
      .pc(b_pc), .pc_plus4(b_pc_plus4), .if_valid(b_if_valid), .flush_ifid(b_flush_ifid),
      .flush_idex(b_flush_idex), .busy(b_busy), .redirect_cnt(b_redirect_cnt),
      .misalign(b_misalign)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: pc, strobe cycles still owed after the current one,
   // accepted-redirect count and sticky misalignment.
   localparam int FC      = 2;
   localparam int CNT_MAX = 65535;
   logic [31:0] m_pc;
   int          m_win;
   int          m_cnt;
   bit          m_mis;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc  = 32'h0000_3000;
      m_win = 0;
      m_cnt = 0;
      m_mis = 1'b0;
   endtask

   // One clock cycle: drive at negedge, compare mid-cycle, advance model at posedge.
   task automatic step(input logic r, input logic s, input logic p, input logic [31:0] t);
      bit in_fl, acc, fl;
      @(negedge clk);
      rst_n = r; stall = s; pcsrc = p; target = t;
      #1;
      in_fl = (m_win > 0);
      acc   = r && !in_fl && p;
      fl    = r && (in_fl || acc);
      check("pc", pc, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
      check("flush_ifid", flush_ifid, fl);
      check("flush_idex", flush_idex, fl);
      check("busy", busy, r && in_fl);
      check("if_valid", if_valid, r && !fl);
      check("redirect_cnt", redirect_cnt, m_cnt);
      check("misalign", misalign, m_mis);
      @(posedge clk);
      if (!r) begin
         model_reset();
      end else if (acc) begin
         m_pc  = t & 32'hFFFF_FFFC;
         m_win = FC - 1;
         m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
         if (t[1:0] != 2'b00) m_mis = 1'b1;
      end else begin
         if (in_fl) m_win--;
         if (!s) m_pc = m_pc + 32'd4;
      end
   endtask

   initial begin
      logic [31:0] last_b;
      rst_n = 1'b0; stall = 1'b0; pcsrc = 1'b0; target = '0;
      b_rst_n = 1'b0; b_stall = 1'b0; b_pcsrc = 1'b0; b_target = '0;
      repeat (2) @(posedge clk);
      model_reset();

      // Reset cycle itself: strobes, busy and if_valid low.
      step(1'b0, 1'b0, 1'b0, 32'h0);
      // Free run, then redirect from 0x3008 to 0x3040.
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b1, 32'h0000_3040);
      #1 check("tp_pc_target", pc, 32'h0000_3040);
      // pcsrc inside the window is ignored; first RUN cycle accepts.
      step(1'b1, 1'b0, 1'b1, 32'h0000_5000);
      #1 check("tp_pc_ignored", pc, 32'h0000_3044);
      step(1'b1, 1'b0, 1'b1, 32'h0000_5000);
      #1 check("tp_pc_b2b", pc, 32'h0000_5000);
      check("tp_cnt_2", redirect_cnt, 32'd2);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      // Get to 0x3010, stall during FLUSH and RUN, then redirect with stall.
      step(1'b1, 1'b0, 1'b1, 32'h0000_3010);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 32'h0000_3102);
      #1 check("tp_pc_misalign", pc, 32'h0000_3100);
      check("tp_misalign", misalign, 1'b1);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      // Wrap-around.
      step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
      repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
      #1 check("tp_pc_wrap", pc, 32'h0000_0004);
      check("tp_misalign_sticky", misalign, 1'b1);
      // Reset during the FLUSH cycle aborts the window.
      step(1'b1, 1'b0, 1'b1, 32'h0000_4000);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 4) == 0), $urandom);
      end

      // Saturation with CNT_W=4 and FLUSH_CYCLES=1: every cycle accepts.
      @(negedge clk);
      b_rst_n = 1'b0;
      @(negedge clk);
      b_rst_n = 1'b1;
      b_pcsrc = 1'b1;
      last_b  = '0;
      for (int i = 0; i < 17; i++) begin
         b_target = $urandom & 32'hFFFF_FFFC;
         #1;
         check("b_flush", b_flush_ifid & b_flush_idex, 1'b1);
         check("b_busy", b_busy, 1'b0);
         check("b_cnt", b_redirect_cnt, (i < 15) ? i : 15);
         last_b = b_target;
         @(negedge clk);
      end
      b_pcsrc = 1'b0;
      #1;
      check("b_cnt_sat", b_redirect_cnt, 32'd15);
      check("b_pc", b_pc, last_b);
      check("b_pc_plus4", b_pc_plus4, last_b + 32'd4);
      check("b_idle_flush", b_flush_ifid | b_flush_idex, 1'b0);
      check("b_if_valid", b_if_valid, 1'b1);
      check("b_misalign", b_misalign, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
